// File: rtl/stumps_bist_ctrl.sv
// STUMPS logic-BIST engine: a shared pattern LFSR feeds the scan chains through a
// phase shifter, a MISR compacts the chain tails, and an FSM sequences the run.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; LFSR/MISR hold
// S_SHIFT   | chains shifting one pattern in (and the previous response out)
// S_CAPTURE | single functional clock into the chains
// S_UNLOAD  | final shift-out of the last captured response
// S_DONE    | signature compared against golden; leaves when start drops
module stumps_bist_ctrl #(
   parameter int                CHAINS    = 3,
   parameter int                CHAIN_LEN = 3,
   parameter int                PATTERNS  = 16,
   parameter int                LFSR_W    = 8,
   parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
   parameter int                MISR_W    = 8,
   parameter logic [MISR_W-1:0] MISR_TAPS = 8'hB8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [MISR_W-1:0] golden,
   input  logic [CHAINS-1:0] scan_out,
   output logic              TC,
   output logic [CHAINS-1:0] scan_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [MISR_W-1:0] signature
);

   localparam int SC_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam int PC_W = (PATTERNS > 1) ? $clog2(PATTERNS) : 1;
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(CHAIN_LEN - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PATTERNS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_CAPTURE,
      S_UNLOAD,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [SC_W-1:0]   shift_cnt, shift_cnt_nxt;
   logic [PC_W-1:0]   pat_cnt, pat_cnt_nxt;
   logic [LFSR_W-1:0] lfsr, lfsr_nxt, lfsr_step;
   logic [MISR_W-1:0] misr, misr_nxt, misr_step;

   assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
   assign misr_step = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ MISR_W'(scan_out);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      shift_cnt_nxt = shift_cnt;
      pat_cnt_nxt   = pat_cnt;
      lfsr_nxt      = lfsr;
      misr_nxt      = misr;
      if (abort) begin
         // LFSR/MISR deliberately hold so the partial signature stays visible
         state_nxt     = S_IDLE;
         shift_cnt_nxt = '0;
         pat_cnt_nxt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state_nxt     = S_SHIFT;
                  lfsr_nxt      = LFSR_SEED;
                  misr_nxt      = '0;
                  shift_cnt_nxt = '0;
                  pat_cnt_nxt   = '0;
               end
            end
            S_SHIFT: begin
               lfsr_nxt = lfsr_step;
               // first load shifts out pre-run chain contents, keep it out of the signature
               if (pat_cnt != '0) begin
                  misr_nxt = misr_step;
               end
               if (shift_cnt == SC_LAST) begin
                  shift_cnt_nxt = '0;
                  state_nxt     = S_CAPTURE;
               end else begin
                  shift_cnt_nxt = shift_cnt + SC_W'(1);
               end
            end
            S_CAPTURE: begin
               if (pat_cnt == PC_LAST) begin
                  state_nxt = S_UNLOAD;
               end else begin
                  pat_cnt_nxt = pat_cnt + PC_W'(1);
                  state_nxt   = S_SHIFT;
               end
            end
            S_UNLOAD: begin
               lfsr_nxt = lfsr_step;
               misr_nxt = misr_step;
               if (shift_cnt == SC_LAST) begin
                  shift_cnt_nxt = '0;
                  state_nxt     = S_DONE;
               end else begin
                  shift_cnt_nxt = shift_cnt + SC_W'(1);
               end
            end
            S_DONE: begin
               if (!start) begin
                  state_nxt = S_IDLE;
               end
            end
            default: begin
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_cnt <= '0;
         pat_cnt   <= '0;
         lfsr      <= LFSR_SEED;
         misr      <= '0;
         TC        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         shift_cnt <= shift_cnt_nxt;
         pat_cnt   <= pat_cnt_nxt;
         lfsr      <= lfsr_nxt;
         misr      <= misr_nxt;
         TC        <= (state == S_IDLE) || (state == S_CAPTURE) || (state == S_DONE);
         busy      <= (state == S_SHIFT) || (state == S_CAPTURE) || (state == S_UNLOAD);
         done      <= (state == S_DONE);
         pass      <= (state == S_DONE) && (misr == golden);
      end
   end

   assign signature = misr;

   for (genvar i = 0; i < CHAINS; i++) begin : g_phase
      localparam int J = (i + LFSR_W / 2) % LFSR_W;
      assign scan_in[i] = lfsr[i] ^ lfsr[J];
   end

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// Bench for stumps_bist_ctrl: two configurations driven by shift-register CUT models,
// checked every cycle against a run-position model of the BIST schedule.
module tb_stumps_bist_ctrl;

   localparam int         MC = 3, ML = 3, MP = 4, MLW = 8, MMW = 8;
   localparam logic [7:0] M_LT = 8'hB8, M_SEED = 8'h01, M_MT = 8'hB8;
   localparam int          WC = 5, WL = 4, WP = 5, WLW = 16, WMW = 16;
   localparam logic [15:0] W_LT = 16'hB400, W_SEED = 16'hACE1, W_MT = 16'hB400;

   typedef struct packed {
      logic signed [31:0] pos;
      logic [15:0]        lfsr;
      logic [15:0]        misr;
      logic               tc;
      logic               busy;
      logic               done;
      logic               pass;
   } mdl_t;

   logic clk, rst, start, abort;
   logic [7:0]  golden_m;
   logic [2:0]  scan_out_m, scan_in_m, noise_m;
   logic        tc_m, busy_m, done_m, pass_m;
   logic [7:0]  sig_m;
   logic [15:0] golden_w;
   logic [4:0]  scan_out_w, scan_in_w;
   logic        tc_w, busy_w, done_w, pass_w, stuck;
   logic [15:0] sig_w;

   int n_chk = 0;
   int n_err = 0;

   stumps_bist_ctrl #(
      .CHAINS(MC), .CHAIN_LEN(ML), .PATTERNS(MP), .LFSR_W(MLW), .LFSR_TAPS(M_LT),
      .LFSR_SEED(M_SEED), .MISR_W(MMW), .MISR_TAPS(M_MT)
   ) u_dut_m (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden_m),
      .scan_out(scan_out_m), .TC(tc_m), .scan_in(scan_in_m), .busy(busy_m),
      .done(done_m), .pass(pass_m), .signature(sig_m)
   );

   stumps_bist_ctrl #(
      .CHAINS(WC), .CHAIN_LEN(WL), .PATTERNS(WP), .LFSR_W(WLW), .LFSR_TAPS(W_LT),
      .LFSR_SEED(W_SEED), .MISR_W(WMW), .MISR_TAPS(W_MT)
   ) u_dut_w (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .golden(golden_w),
      .scan_out(scan_out_w), .TC(tc_w), .scan_in(scan_in_w), .busy(busy_w),
      .done(done_w), .pass(pass_w), .signature(sig_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] wmask(input int w);
      return 16'((32'd1 << w) - 32'd1);
   endfunction

   function automatic logic [15:0] shift_fb(input logic [15:0] v, input int w, input logic [15:0] taps);
      return ((v << 1) | {15'b0, ^(v & taps)}) & wmask(w);
   endfunction

   function automatic logic [15:0] phase(input logic [15:0] v, input int w, input int chains);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < chains; i++) r[i] = v[i] ^ v[(i + w / 2) % w];
      return r;
   endfunction

   function automatic mdl_t mdl_reset(input logic [15:0] seed);
      mdl_t n;
      n.pos = -1; n.lfsr = seed; n.misr = '0;
      n.tc = 1'b1; n.busy = 1'b0; n.done = 1'b0; n.pass = 1'b0;
      return n;
   endfunction

   // A run is a position counted in cycles from the start edge; every phase of the
   // schedule follows from that position. Outputs are the previous position's view.
   function automatic mdl_t mdl_step(input mdl_t s, input int p, input int l, input int lw,
                                     input logic [15:0] lt, input logic [15:0] seed,
                                     input int mw, input logic [15:0] mt, input logic st,
                                     input logic ab, input logic [15:0] gold,
                                     input logic [15:0] so);
      mdl_t n;
      int   runlen, slot;
      bit   idle, fin, unl, shf, cap;
      n      = s;
      runlen = p * (l + 1) + l;
      idle   = s.pos < 0;
      fin    = s.pos >= runlen;
      unl    = !idle && !fin && s.pos >= p * (l + 1);
      slot   = idle ? 0 : s.pos % (l + 1);
      shf    = !idle && !fin && !unl && slot < l;
      cap    = !idle && !fin && !unl && slot == l;
      n.tc   = idle || cap || fin;
      n.busy = shf || cap || unl;
      n.done = fin;
      n.pass = fin && (s.misr == (gold & wmask(mw)));
      if (ab) begin
         n.pos = -1;
      end else if (idle) begin
         if (st) begin
            n.pos = 0; n.lfsr = seed; n.misr = '0;
         end
      end else if (fin) begin
         if (!st) n.pos = -1;
      end else begin
         n.pos = s.pos + 1;
         if (shf || unl) n.lfsr = shift_fb(s.lfsr, lw, lt);
         if (unl || (shf && (s.pos / (l + 1)) != 0))
            n.misr = shift_fb(s.misr, mw, mt) ^ (so & wmask(mw));
      end
      return n;
   endfunction

   mdl_t mdl_m, mdl_w;

   always @(posedge clk or posedge rst) begin
      if (rst) mdl_m <= mdl_reset(16'(M_SEED));
      else mdl_m <= mdl_step(mdl_m, MP, ML, MLW, 16'(M_LT), 16'(M_SEED), MMW, 16'(M_MT),
                             start, abort, 16'(golden_m), 16'(scan_out_m));
   end

   always @(posedge clk or posedge rst) begin
      if (rst) mdl_w <= mdl_reset(W_SEED);
      else mdl_w <= mdl_step(mdl_w, WP, WL, WLW, W_LT, W_SEED, WMW, W_MT,
                             start, abort, golden_w, 16'(scan_out_w));
   end

   // CUT: CHAIN_LEN flops per chain, shift on TC=0, capture inverts chain contents
   logic [2:0] cut_m [ML];
   logic [4:0] cut_w [WL];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ML; k++) cut_m[k] <= '0;
      end else if (!tc_m) begin
         cut_m[0] <= scan_in_m;
         for (int k = 1; k < ML; k++) cut_m[k] <= cut_m[k-1];
      end else begin
         for (int k = 0; k < ML; k++) cut_m[k] <= ~cut_m[k];
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < WL; k++) cut_w[k] <= '0;
      end else if (!tc_w) begin
         cut_w[0] <= scan_in_w;
         for (int k = 1; k < WL; k++) cut_w[k] <= cut_w[k-1];
      end else begin
         for (int k = 0; k < WL; k++) cut_w[k] <= ~cut_w[k];
      end
   end

   assign scan_out_m = cut_m[ML-1] ^ noise_m;
   assign scan_out_w = cut_w[WL-1] & (stuck ? 5'b01111 : 5'b11111);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("tc_m", 32'(tc_m), 32'(mdl_m.tc));
         chk("busy_m", 32'(busy_m), 32'(mdl_m.busy));
         chk("done_m", 32'(done_m), 32'(mdl_m.done));
         chk("pass_m", 32'(pass_m), 32'(mdl_m.pass));
         chk("sig_m", 32'(sig_m), 32'(mdl_m.misr));
         chk("scan_in_m", 32'(scan_in_m), 32'(phase(mdl_m.lfsr, MLW, MC)));
         chk("tc_w", 32'(tc_w), 32'(mdl_w.tc));
         chk("busy_w", 32'(busy_w), 32'(mdl_w.busy));
         chk("done_w", 32'(done_w), 32'(mdl_w.done));
         chk("pass_w", 32'(pass_w), 32'(mdl_w.pass));
         chk("sig_w", 32'(sig_w), 32'(mdl_w.misr));
         chk("scan_in_w", 32'(scan_in_w), 32'(phase(mdl_w.lfsr, WLW, WC)));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done_m();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (done_m) seen = 1'b1;
      end
      if (!seen) chk("done_m_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_done_w();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         if (done_w) seen = 1'b1;
      end
      if (!seen) chk("done_w_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  sig_ref, part_sig;
      logic [15:0] sig_w0;
      int          first_done, busy_cnt, tc_low;
      int          start_len, abort_at;
      bit          noise_en, gm_hit, gw_hit;

      rst = 1'b1; start = 1'b0; abort = 1'b0; golden_m = '0; golden_w = '0;
      noise_m = '0; stuck = 1'b0;
      sig_ref = '0; first_done = -1; busy_cnt = 0; tc_low = 0;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_tc", 32'(tc_m), 32'd1);
      chk("reset_sig", 32'(sig_m), 32'd0);
      chk("reset_scan_in", 32'(scan_in_m), 32'b001);

      // run timing: start sampled at edge 0, k is the edge just before each sample
      tick();
      pulse();
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (k == 0) chk("scan_in_e0", 32'(scan_in_m), 32'b001);
         if (k == 1) chk("scan_in_e1", 32'(scan_in_m), 32'b010);
         if (k == 2) chk("scan_in_e2", 32'(scan_in_m), 32'b100);
         if (k == 3) chk("sig_pat0", 32'(sig_m), 32'd0);
         if (busy_m) busy_cnt++;
         if (!tc_m) tc_low++;
         if (done_m && first_done < 0) begin
            first_done = k;
            sig_ref    = mdl_m.misr[7:0];
         end
         if (done_m && busy_m) chk("done_and_busy", 32'd1, 32'd0);
      end
      chk("done_edge", 32'(first_done), 32'd20);
      chk("busy_cycles", 32'(busy_cnt), 32'd19);
      chk("tc_low_cycles", 32'(tc_low), 32'd15);
      repeat (12) tick();

      golden_m = sig_ref;
      pulse();
      wait_done_m();
      chk("pass_on_match", 32'(pass_m), 32'd1);
      chk("sig_rerun", 32'(sig_m), 32'(sig_ref));
      repeat (15) tick();

      golden_m = sig_ref ^ 8'h01;
      pulse();
      wait_done_m();
      chk("pass_on_mismatch", 32'(pass_m), 32'd0);
      repeat (15) tick();

      // start held through DONE must not retrigger
      start = 1'b1;
      tick();
      wait_done_m();
      repeat (8) tick();
      @(negedge clk);
      chk("hold_done", 32'(done_m), 32'd1);
      chk("hold_busy", 32'(busy_m), 32'd0);
      start = 1'b0;
      repeat (15) tick();
      pulse();
      wait_done_m();
      chk("sig_restart", 32'(sig_m), 32'(sig_ref));
      repeat (15) tick();

      // abort during pattern 2 capture (run position 11)
      pulse();
      repeat (11) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      part_sig = mdl_m.misr[7:0];
      repeat (2) tick();
      @(negedge clk);
      chk("abort_busy", 32'(busy_m), 32'd0);
      chk("abort_done", 32'(done_m), 32'd0);
      chk("abort_sig_hold", 32'(sig_m), 32'(part_sig));
      repeat (15) tick();
      pulse();
      wait_done_m();
      chk("sig_after_abort", 32'(sig_m), 32'(sig_ref));
      repeat (15) tick();

      // start and abort together in IDLE
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tick();
      @(negedge clk);
      chk("start_abort_idle", 32'(busy_m), 32'd0);
      repeat (3) tick();

      // asynchronous reset in the middle of pattern 1 shifting
      pulse();
      repeat (6) tick();
      rst = 1'b1;
      #1;
      chk("rst_tc", 32'(tc_m), 32'd1);
      chk("rst_busy", 32'(busy_m), 32'd0);
      chk("rst_done", 32'(done_m), 32'd0);
      chk("rst_sig", 32'(sig_m), 32'd0);
      chk("rst_scan_in", 32'(scan_in_m), 32'b001);
      tick();
      rst = 1'b0;
      repeat (3) tick();

      // wide configuration: stuck-at-0 on the top chain tail must move the signature
      pulse();
      wait_done_w();
      sig_w0 = mdl_w.misr;
      chk("sig_w_clean", 32'(sig_w), 32'(sig_w0));
      repeat (4) tick();
      stuck = 1'b1;
      pulse();
      wait_done_w();
      n_chk++;
      if (sig_w == sig_w0) begin
         n_err++;
         $display("FAIL stuck_at_sig: got 0x%0h expected a value other than 0x%0h", sig_w, sig_w0);
      end
      stuck = 1'b0;
      repeat (4) tick();

      // randomized runs: noisy chain tails, random start length, random aborts and goldens
      for (int it = 0; it < 25; it++) begin
         noise_en  = 1'($urandom_range(0, 1));
         start_len = int'($urandom_range(1, 3));
         abort_at  = int'($urandom_range(0, 79));
         gm_hit    = 1'($urandom_range(0, 1));
         gw_hit    = 1'($urandom_range(0, 1));
         start = 1'b1;
         for (int c = 0; c < 40; c++) begin
            tick();
            start   = (c + 1 < start_len);
            abort   = (c == abort_at);
            noise_m = noise_en ? 3'($urandom) : 3'b000;
            if (c == 19) golden_m = gm_hit ? mdl_m.misr[7:0] : 8'($urandom);
            if (c == 29) golden_w = gw_hit ? mdl_w.misr : 16'($urandom);
         end
         start = 1'b0; abort = 1'b0; noise_m = '0;
         repeat (2) tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
